// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared defaults, widths and FSM state encoding for the FIFO write arbiter.
// Imported by the top and by the round-robin picker.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_W     = 4;
    localparam int DEF_FIFO_DEPTH = 10;
    localparam int DEF_CNT_W      = $clog2(DEF_FIFO_DEPTH + 1);
    localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

    typedef logic [DEF_CNT_W-1:0] occ_t;
    typedef logic [DEF_ID_W-1:0]  req_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past ptr_i and wraps.
// Latency: zero. Backpressure: none, pure function of req_i and ptr_i.
// Returns a one-hot grant, its index, and whether anything was picked.
module rr_pick #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter + occupancy tracker for the shared data FIFO (lock mode: FIFO_ARB_LOCK_EN).
// Latency: 1 cycle from handshake to fifo_wr_en.
// Backpressure: req_ready held low while occupancy == FIFO_DEPTH; a same-cycle pop frees nothing.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [ID_W-1:0]           fifo_wr_id,
    input  logic                      fifo_rd_en,
    output logic [CNT_W-1:0]          occupancy,
    output logic                      full,
    output logic                      empty,
    output logic                      err_underflow
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ID_W-1:0]    wr_id_q, wr_id_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               err_q, err_d;

    logic               space;
    logic               push;
    logic               pop_eff;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    assign space = (occ_q < CNT_W'(FIFO_DEPTH));

`ifdef FIFO_ARB_LOCK_EN
    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;

    always_comb begin
        elig = space ? req_valid : '0;
        if (state_q == LOCKED) begin
            elig = elig & (NUM_REQ'(1) << owner_q);
        end
    end

    // Release on the owner's last locked beat, or as soon as it stops requesting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB: begin
                if (push && req_lock[gnt_idx]) begin
                    state_d = LOCKED;
                    owner_d = gnt_idx;
                end
            end
            LOCKED: begin
                if (!req_valid[owner_q] || (push && !req_lock[owner_q])) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`else
    assign elig = space ? req_valid : '0;
`endif

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_i (elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_ready = rst ? '0 : gnt;
    assign push      = gnt_any & ~rst;
    assign pop_eff   = fifo_rd_en && (occ_q != '0);

    always_comb begin
        wr_en_d   = push;
        wr_data_d = wr_data_q;
        wr_id_d   = wr_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (push) begin
            wr_data_d = req_data[gnt_idx*DATA_W +: DATA_W];
            wr_id_d   = gnt_idx;
            rr_ptr_d  = gnt_idx;
        end
        occ_d   = occ_q + CNT_W'(push) - CNT_W'(pop_eff);
        full_d  = (occ_d == CNT_W'(FIFO_DEPTH));
        empty_d = (occ_d == '0);
        err_d   = err_q | (fifo_rd_en && (occ_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= ID_W'(NUM_REQ - 1);
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_id_q   <= '0;
            occ_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_id_q   <= wr_id_d;
            occ_q     <= occ_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            err_q     <= err_d;
        end
    end

    assign fifo_wr_en    = wr_en_q;
    assign fifo_wr_data  = wr_data_q;
    assign fifo_wr_id    = wr_id_q;
    assign occupancy     = occ_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed steps then random traffic against a queue-level model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 10;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_lock;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [IW-1:0]   fifo_wr_id;
    logic            fifo_rd_en;
    logic [CW-1:0]   occupancy;
    logic            full;
    logic            empty;
    logic            err_underflow;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
`ifdef FIFO_ARB_LOCK_EN
        .req_lock      (req_lock),
`endif
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_id    (fifo_wr_id),
        .fifo_rd_en    (fifo_rd_en),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .err_underflow (err_underflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: beats held, last winner, sticky error, expected registered beat.
    int            m_occ;
    int            m_last;
    bit            m_err;
    logic          m_wr_en;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_id;
    bit            m_locked;
    int            m_owner;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_occ    = 0;
        m_last   = N - 1;
        m_err    = 1'b0;
        m_wr_en  = 1'b0;
        m_data   = '0;
        m_id     = '0;
        m_locked = 1'b0;
        m_owner  = 0;
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (rst || m_occ >= DEPTH) return g;
`ifdef FIFO_ARB_LOCK_EN
        if (m_locked) begin
            if (req_valid[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
`endif
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) begin
                g[(m_last + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, ".wr_en"},   32'(fifo_wr_en),    32'(m_wr_en));
        chk({tag, ".wr_data"}, 32'(fifo_wr_data),  32'(m_data));
        chk({tag, ".wr_id"},   32'(fifo_wr_id),    32'(m_id));
        chk({tag, ".occ"},     32'(occupancy),     32'(m_occ));
        chk({tag, ".full"},    32'(full),          32'(m_occ == DEPTH));
        chk({tag, ".empty"},   32'(empty),         32'(m_occ == 0));
        chk({tag, ".err"},     32'(err_underflow), 32'(m_err));
    endtask

    // One clock: inputs already driven; ready checked at negedge, registers #1 after posedge.
    task automatic cycle(input string tag);
        logic [N-1:0] g;
        int w;
        @(negedge clk);
        g = exp_grant();
        chk({tag, ".ready"}, 32'(req_ready), 32'(g));
        w = -1;
        for (int i = 0; i < N; i++) if (g[i]) w = i;
`ifdef FIFO_ARB_LOCK_EN
        if (!m_locked) begin
            if (w >= 0 && req_lock[w]) begin
                m_locked = 1'b1;
                m_owner  = w;
            end
        end else if (!req_valid[m_owner] || (w >= 0 && !req_lock[m_owner])) begin
            m_locked = 1'b0;
        end
`endif
        if (fifo_rd_en && m_occ == 0) m_err = 1'b1;
        if (fifo_rd_en && m_occ > 0) m_occ--;
        if (w >= 0) begin
            m_occ++;
            m_wr_en = 1'b1;
            m_data  = req_data[w*DW +: DW];
            m_id    = IW'(w);
            m_last  = w;
        end else begin
            m_wr_en = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_regs(tag);
    endtask

    // Called just after a posedge; the pulse sits well clear of both clock edges.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.ready", 32'(req_ready), 32'(0));
        chk_regs("arst");
        #1 rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_lock   = '0;
        fifo_rd_en = 1'b0;
        model_reset();

        // Reset state, with all producers requesting.
        #1 rst = 1'b1;
        req_valid = 4'b1111;
        req_data  = 16'h4321;
        #1;
        chk("rst.ready", 32'(req_ready), 32'(0));
        chk_regs("rst");
        @(posedge clk);
        #1;
        chk("rst_hold.ready", 32'(req_ready), 32'(0));
        rst = 1'b0;

        // Fill from reset: grants 0,1,2,3,0,... until full.
        for (int i = 0; i < 12; i++) begin
            req_data = 16'(($urandom));
            cycle("fill");
        end
        chk("fill.occ10", 32'(occupancy), 32'(DEPTH));
        chk("fill.full", 32'(full), 32'(1));

        // One pop while full: no grant in the pop cycle, one grant right after.
        fifo_rd_en = 1'b1;
        cycle("pop_full");
        fifo_rd_en = 1'b0;
        cycle("resume");
        cycle("refull");

        // Drain completely, then pop on empty to raise the sticky error.
        req_valid  = '0;
        fifo_rd_en = 1'b1;
        for (int i = 0; i < 11; i++) cycle("drain");
        fifo_rd_en = 1'b0;
        for (int i = 0; i < 2; i++) cycle("sticky");

        // Build to 5, then push and pop together.
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            req_data = 16'(($urandom));
            cycle("to5");
        end
        req_data   = 16'h9ABC;
        fifo_rd_en = 1'b1;
        cycle("pushpop");
        chk("pushpop.occ5", 32'(occupancy), 32'(5));
        fifo_rd_en = 1'b0;

        // Single producer 2 with data A, then reset while its beat is on the write port.
        req_valid = 4'b0100;
        req_data  = 16'h0A00;
        cycle("solo2");
        chk("solo2.data", 32'(fifo_wr_data), 32'(4'hA));
        pulse_reset();
        req_valid = '0;
        cycle("post_rst");

`ifdef FIFO_ARB_LOCK_EN
        // Producer 1 locks for three beats, releasing on the third; producer 2 is next.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        req_data  = 16'h5555;
        cycle("lock1");
        req_valid = 4'b1111;
        cycle("lock2");
        req_lock  = 4'b0000;
        cycle("lock3");
        cycle("unlock");
        chk("unlock.id2", 32'(fifo_wr_id), 32'(2));
        req_valid = '0;
        pulse_reset();
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            req_valid  = N'($urandom);
            req_data   = 16'(($urandom));
            req_lock   = N'($urandom);
            fifo_rd_en = ($urandom_range(0, 9) < 4);
            cycle("rand");
            if (i % 97 == 96) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter and occupancy tracker for the shared 4-bit data FIFO.
- Up to NUM_REQ producers raise valid/data; the block grants one per cycle and registers the winning beat onto the FIFO write port.
- Tracks FIFO occupancy from accepted pushes and consumer pops, so producers are back-pressured before overflow. The FIFO itself needs no full/empty logic.

Parameters:
- NUM_REQ, 4, number of producer requesters (2..8)
- DATA_W, 4, data width per beat
- FIFO_DEPTH, 10, entries in the downstream FIFO
- CNT_W (localparam), $clog2(FIFO_DEPTH+1), occupancy width
- ID_W (localparam), $clog2(NUM_REQ), grant index width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer beat valid
- req_data  in  NUM_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; combinational from registered state and req_valid
- fifo_wr_en  out  1  registered push strobe to FIFO
- fifo_wr_data  out  DATA_W  registered push data
- fifo_wr_id  out  ID_W  registered index of the producer that supplied the beat
- fifo_rd_en  in  1  consumer pop request, observed alongside the FIFO
- occupancy  out  CNT_W  accepted-but-not-popped beats
- full  out  1  occupancy == FIFO_DEPTH
- empty  out  1  occupancy == 0
- err_underflow  out  1  sticky; pop seen while empty
- req_lock  in  NUM_REQ  present only with FIFO_ARB_LOCK_EN

Behaviour:
- Reset (async, while rst=1):
  - fifo_wr_en=0, fifo_wr_data=0, fifo_wr_id=0
  - occupancy=0, full=0, empty=1, err_underflow=0
  - rr_ptr=NUM_REQ-1, so producer 0 wins first
  - req_ready=0 while rst is high
- Credit: space = (occupancy < FIFO_DEPTH).
  - A pop in the same cycle does NOT create space. This is a deliberate, conservative choice.
- Arbitration:
  - If space=1, search req_valid starting at rr_ptr+1 mod NUM_REQ and wrap; the first set bit wins.
  - req_ready has exactly that bit set; otherwise req_ready=0.
  - req_ready never asserts for a requester with req_valid=0.
- Transfer: valid & ready for winner w.
  - Next edge: fifo_wr_en=1, fifo_wr_data=req_data[w], fifo_wr_id=w, rr_ptr=w.
  - With no transfer: fifo_wr_en=0; data and id hold their previous values.
- Latency: 1 cycle from accepted handshake to fifo_wr_en.
- Pop is effective when fifo_rd_en=1 and occupancy>0.
  - fifo_rd_en=1 with occupancy=0: pop ignored, err_underflow set (cleared only by rst).
- Occupancy next = occupancy + push − effective_pop.
  - Push and pop together leave it unchanged.
  - Saturation cannot occur by construction.
- full and empty are registered, derived from next occupancy. They are valid in the same cycle as occupancy.
- Fairness: with all NUM_REQ valid and continuous space, each requester is granted once per NUM_REQ consecutive grants.
- rst asserted mid-stream: any pending registered beat is dropped (fifo_wr_en=0 immediately). The FIFO is reset by the same rst.

Optional Feature:
- Macro: FIFO_ARB_LOCK_EN
- Defined:
  - req_lock port exists; arbiter is a 2-state FSM, ARB and LOCKED.
  - ARB -> LOCKED when the winner w transfers with req_lock[w]=1; owner=w.
  - In LOCKED, only the owner may be granted (subject to space). Others see ready=0 even if valid.
  - LOCKED -> ARB on a transfer from the owner with req_lock[owner]=0, or when req_valid[owner]=0.
  - rr_ptr still updates to owner on each of its transfers.
- Undefined: no req_lock port; pure round-robin as above.

Decomposition:
- Package fifo_arb_pkg: DATA_W/FIFO_DEPTH defaults, occupancy and ID typedefs, FSM state enum {ARB, LOCKED}.
- One sub-module is natural: rr_pick, a combinational round-robin priority picker (req vector, pointer -> one-hot grant + index).
- Occupancy counter and output registers stay in the top.

Test Plan:
- Reset release, NUM_REQ=4, req_valid=4'b1111 steady, no pops -> grants 0,1,2,3,0,…; fifo_wr_en one cycle after each handshake; after 10 pushes full=1, req_ready=0, occupancy=10.
- Full FIFO, fifo_rd_en=1 for one cycle, all valid -> occupancy 10→9 next edge; grant resumes the cycle after, not the pop cycle.
- Empty, fifo_rd_en=1 -> occupancy stays 0, err_underflow=1 and sticky until rst.
- Push and pop together at occupancy=5 -> occupancy stays 5; fifo_wr_data equals winner's data, fifo_wr_id correct.
- Only req_valid[2]=1 with data 4'hA -> ready[2] immediately; next edge fifo_wr_en=1, data=4'hA, id=2; rst pulse mid-stream -> all outputs to reset values asynchronously.
- FIFO_ARB_LOCK_EN: requester 1 holds req_lock=1 for 3 beats with all valid -> grants 1,1,1; dropping lock on the third beat -> next grant goes to 2.
